// File: rtl/mdr_pkg.sv
// mdr_pkg: shared definitions for the MDR operand loader.
//   DW                      operand/result width
//   DEFAULT_TIMEOUT_CYCLES  default watchdog limit for any wait state
//   mdr_op_t                operation encodings (2'b11 is illegal)
//   loader_state_t          loader FSM state encoding
package mdr_pkg;

  localparam int DW = 16;
  localparam int DEFAULT_TIMEOUT_CYCLES = 1023;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_DIV  = 2'b01,
    OP_SQRT = 2'b10
  } mdr_op_t;

  localparam logic [1:0] OP_ILLEGAL = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_X,
    ST_LOAD_X,
    ST_WAIT_Y,
    ST_LOAD_Y,
    ST_WAIT_RDY,
    ST_RESP
  } loader_state_t;

  // States in which the loader waits on the MDR and the watchdog runs.
  function automatic logic is_wait(loader_state_t s);
    return (s == ST_WAIT_X) || (s == ST_WAIT_Y) || (s == ST_WAIT_RDY);
  endfunction

endpackage

// File: rtl/mdr_operand_loader_if.sv
// mdr_operand_loader_if: host request/response and MDR load bus.
//   master modport: the loader (accepts requests, drives MDR commands,
//                   returns responses)
//   slave modport : the environment (host plus MDR core)
//
// Handshake rules:
//   - A request transfers on a rising edge where req_valid && req_ready;
//     req_ready is high only while the loader is idle.
//   - mdr_start, mdr_load and rsp_valid are single-cycle pulses with no
//     back-pressure; mdr_data is meaningful only while mdr_load is high.
//   - mdr_load_x / mdr_load_y / mdr_ready / mdr_error are sampled on each
//     rising edge while the loader is waiting for them.
interface mdr_operand_loader_if;
  import mdr_pkg::*;

  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op;
  logic [DW-1:0] req_x;
  logic [DW-1:0] req_y;

  logic          mdr_start;
  logic [1:0]    mdr_op;
  logic          mdr_load;
  logic [DW-1:0] mdr_data;
  logic          mdr_load_x;
  logic          mdr_load_y;
  logic          mdr_ready;
  logic          mdr_error;
  logic [DW-1:0] mdr_result;
  logic [DW-1:0] mdr_reminder;

  logic          rsp_valid;
  logic [DW-1:0] rsp_result;
  logic [DW-1:0] rsp_reminder;
  logic          rsp_error;
  logic          rsp_timeout;

  modport master (
    input  req_valid, req_op, req_x, req_y,
    input  mdr_load_x, mdr_load_y, mdr_ready, mdr_error, mdr_result, mdr_reminder,
    output req_ready, mdr_start, mdr_op, mdr_load, mdr_data,
    output rsp_valid, rsp_result, rsp_reminder, rsp_error, rsp_timeout
  );

  modport slave (
    output req_valid, req_op, req_x, req_y,
    output mdr_load_x, mdr_load_y, mdr_ready, mdr_error, mdr_result, mdr_reminder,
    input  req_ready, mdr_start, mdr_op, mdr_load, mdr_data,
    input  rsp_valid, rsp_result, rsp_reminder, rsp_error, rsp_timeout
  );

endinterface

// File: rtl/mdr_wdog.sv
// mdr_wdog: wait-state watchdog counter.
//   clk, rst  clock and asynchronous active-low reset
//   clear     zero the counter (asserted on every state change)
//   enable    count this cycle (asserted in wait states)
//   expired   counter has reached TIMEOUT_CYCLES
module mdr_wdog #(
  parameter int TIMEOUT_CYCLES = mdr_pkg::DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] count;

  // The count saturates at the limit so it cannot wrap if the owner
  // lingers in a wait state for an extra cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/mdr_operand_loader.sv
// mdr_operand_loader: initiator side of the MDR operand-load handshake.
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   bus        request/MDR/response signals (master view)
//   dbg_state  current FSM state, for observation only
// Accepts one request, pulses Start, answers Load_X/Load_Y with single
// Load pulses carrying the latched operand, then returns one response
// pulse. A watchdog aborts any wait state that lasts TIMEOUT_CYCLES.
module mdr_operand_loader
  import mdr_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                clk,
  input  logic                rst,
  mdr_operand_loader_if.master bus,
  output loader_state_t       dbg_state
);

  loader_state_t state, next;

  logic [1:0]    op_q;
  logic [DW-1:0] x_q, y_q;
  logic [DW-1:0] rsp_result_q, rsp_reminder_q;
  logic          rsp_error_q, rsp_timeout_q;

  // Response capture, valid only on the transition into RESP.
  logic          cap;
  logic [DW-1:0] cap_result, cap_reminder;
  logic          cap_error, cap_timeout;

  logic          expired;

  mdr_wdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (next != state),
    .enable  (is_wait(state)),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ST_IDLE;
      op_q           <= '0;
      x_q            <= '0;
      y_q            <= '0;
      rsp_result_q   <= '0;
      rsp_reminder_q <= '0;
      rsp_error_q    <= 1'b0;
      rsp_timeout_q  <= 1'b0;
    end else begin
      state <= next;
      if (state == ST_IDLE && bus.req_valid) begin
        op_q <= bus.req_op;
        x_q  <= bus.req_x;
        y_q  <= bus.req_y;
      end
      if (cap) begin
        rsp_result_q   <= cap_result;
        rsp_reminder_q <= cap_reminder;
        rsp_error_q    <= cap_error;
        rsp_timeout_q  <= cap_timeout;
      end
    end
  end

  // Priority inside a wait state: MDR error, then completion, then the
  // requested load, then the watchdog. An error coincident with the
  // timeout is therefore reported as an MDR error, not a timeout.
  always_comb begin
    next         = state;
    cap          = 1'b0;
    cap_result   = '0;
    cap_reminder = '0;
    cap_error    = 1'b0;
    cap_timeout  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          if (bus.req_op == OP_ILLEGAL) begin
            next      = ST_RESP;
            cap       = 1'b1;
            cap_error = 1'b1;
          end else begin
            next = ST_START;
          end
        end
      end
      ST_START: next = ST_WAIT_X;
      ST_WAIT_X, ST_WAIT_Y, ST_WAIT_RDY: begin
        if (bus.mdr_error || (state == ST_WAIT_RDY && bus.mdr_ready)) begin
          next         = ST_RESP;
          cap          = 1'b1;
          cap_result   = bus.mdr_result;
          cap_reminder = bus.mdr_reminder;
          cap_error    = bus.mdr_error;
        end else if (state == ST_WAIT_X && bus.mdr_load_x) begin
          next = ST_LOAD_X;
        end else if (state == ST_WAIT_Y && bus.mdr_load_y) begin
          next = ST_LOAD_Y;
        end else if (expired) begin
          next        = ST_RESP;
          cap         = 1'b1;
          cap_error   = 1'b1;
          cap_timeout = 1'b1;
        end
      end
      ST_LOAD_X: next = (op_q == OP_SQRT) ? ST_WAIT_RDY : ST_WAIT_Y;
      ST_LOAD_Y: next = ST_WAIT_RDY;
      ST_RESP:   next = ST_IDLE;
      default:   next = ST_IDLE;
    endcase
  end

  assign bus.req_ready    = (state == ST_IDLE);
  assign bus.mdr_start    = (state == ST_START);
  assign bus.mdr_op       = op_q;
  assign bus.mdr_load     = (state == ST_LOAD_X) || (state == ST_LOAD_Y);
  assign bus.mdr_data     = (state == ST_LOAD_X) ? x_q :
                            (state == ST_LOAD_Y) ? y_q : '0;
  assign bus.rsp_valid    = (state == ST_RESP);
  assign bus.rsp_result   = rsp_result_q;
  assign bus.rsp_reminder = rsp_reminder_q;
  assign bus.rsp_error    = rsp_error_q;
  assign bus.rsp_timeout  = rsp_timeout_q;
  assign dbg_state        = state;

endmodule

// File: tb/tb_mdr_operand_loader.sv
// tb_mdr_operand_loader: directed and randomized checks of the operand
// loader against an arithmetic reference of the MDR operations. The bench
// plays both host and MDR; all activity happens on falling edges.
module tb_mdr_operand_loader;
  import mdr_pkg::*;

  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst = 1'b0;
  loader_state_t dbg_state;

  mdr_operand_loader_if bus();

  mdr_operand_loader #(.TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout bench did not finish within time limit");
    $fatal(1, "global timeout");
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int n_start  = 0;
  int n_load   = 0;
  int n_rsp    = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkd(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One cycle; outputs are stable at the falling edge, so pulses are
  // counted here.
  task automatic tick();
    @(negedge clk);
    if (bus.mdr_start) n_start++;
    if (bus.mdr_load)  n_load++;
    if (bus.rsp_valid) n_rsp++;
  endtask

  // Reference arithmetic for the three MDR operations.
  function automatic void ref_mdr(input logic [1:0] op, input logic [DW-1:0] a,
                                  input logic [DW-1:0] b, output logic [DW-1:0] res,
                                  output logic [DW-1:0] rem, output logic err);
    int unsigned p, r;
    err = 1'b0;
    res = '0;
    rem = '0;
    case (op)
      2'b00: begin
        p   = 32'(a) * 32'(b);
        res = p[15:0];
        rem = p[31:16];
      end
      2'b01: begin
        if (b == '0) begin
          err = 1'b1;
          res = '1;
          rem = a;
        end else begin
          res = a / b;
          rem = a % b;
        end
      end
      2'b10: begin
        r = 0;
        while ((r + 1) * (r + 1) <= 32'(a)) r++;
        res = DW'(r);
        rem = DW'(32'(a) - r * r);
      end
      default: err = 1'b1;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_req(input logic [1:0] op, input logic [DW-1:0] x, input logic [DW-1:0] y);
    check1("req_ready_idle", bus.req_ready, 1'b1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_x     = x;
    bus.req_y     = y;
    tick();
    bus.req_valid = 1'b0;
    bus.req_op    = 2'($urandom_range(0, 3));
    bus.req_x     = DW'($urandom);
    bus.req_y     = DW'($urandom);
  endtask

  // Entered at the falling edge of a WAIT_X/WAIT_Y cycle; leaves at the
  // falling edge of the following wait state.
  task automatic serve_load(input bit is_y, input int dly, input logic [DW-1:0] exp_val,
                            output logic [DW-1:0] got);
    for (int i = 0; i < dly; i++) begin
      check1(is_y ? "no_load_wait_y" : "no_load_wait_x", bus.mdr_load, 1'b0);
      tick();
    end
    if (is_y) bus.mdr_load_y = 1'b1;
    else      bus.mdr_load_x = 1'b1;
    tick();
    bus.mdr_load_x = 1'b0;
    bus.mdr_load_y = 1'b0;
    check1(is_y ? "load_y_pulse" : "load_x_pulse", bus.mdr_load, 1'b1);
    checkd(is_y ? "load_y_data" : "load_x_data", bus.mdr_data, exp_val);
    got = bus.mdr_data;
    tick();
    check1("load_single_cycle", bus.mdr_load, 1'b0);
    checkd("data_zero_no_load", bus.mdr_data, '0);
  endtask

  // Full transaction with the bench acting as MDR. The MDR side computes
  // from the operands it actually received; the expectation comes from
  // the host request.
  task automatic run_txn(input string name, input logic [1:0] op, input logic [DW-1:0] x,
                         input logic [DW-1:0] y, input int dx, input int dy, input int lat);
    logic [DW-1:0] gx, gy, res, rem, e_res, e_rem;
    logic err, e_err;
    int s0, l0;
    s0 = n_start;
    l0 = n_load;
    ref_mdr(op, x, y, e_res, e_rem, e_err);
    exp_q.push_back(e_res);
    exp_q.push_back(e_rem);
    send_req(op, x, y);
    check1({name, "_start"}, bus.mdr_start, 1'b1);
    check({name, "_mdr_op"}, int'(bus.mdr_op), int'(op));
    tick();
    check1({name, "_start_once"}, bus.mdr_start, 1'b0);
    serve_load(1'b0, dx, x, gx);
    gy = '0;
    if (op != 2'b10) serve_load(1'b1, dy, y, gy);
    ref_mdr(op, gx, gy, res, rem, err);
    for (int i = 0; i < lat; i++) begin
      check1({name, "_no_early_rsp"}, bus.rsp_valid, 1'b0);
      tick();
    end
    bus.mdr_result   = res;
    bus.mdr_reminder = rem;
    if (err) bus.mdr_error = 1'b1;
    else     bus.mdr_ready = 1'b1;
    tick();
    bus.mdr_ready    = 1'b0;
    bus.mdr_error    = 1'b0;
    bus.mdr_result   = DW'($urandom);
    bus.mdr_reminder = DW'($urandom);
    e_res = exp_q.pop_front();
    e_rem = exp_q.pop_front();
    check1({name, "_rsp_valid"}, bus.rsp_valid, 1'b1);
    checkd({name, "_rsp_result"}, bus.rsp_result, e_res);
    checkd({name, "_rsp_reminder"}, bus.rsp_reminder, e_rem);
    check1({name, "_rsp_error"}, bus.rsp_error, e_err);
    check1({name, "_rsp_timeout"}, bus.rsp_timeout, 1'b0);
    check({name, "_op_held"}, int'(bus.mdr_op), int'(op));
    check({name, "_start_count"}, n_start - s0, 1);
    check({name, "_load_count"}, n_load - l0, (op == 2'b10) ? 1 : 2);
    tick();
    check1({name, "_rsp_single"}, bus.rsp_valid, 1'b0);
    check1({name, "_ready_again"}, bus.req_ready, 1'b1);
    checkd({name, "_rsp_held"}, bus.rsp_result, e_res);
  endtask

  task automatic check_reset_outputs(input string name);
    check1({name, "_req_ready"}, bus.req_ready, 1'b1);
    check1({name, "_mdr_start"}, bus.mdr_start, 1'b0);
    check1({name, "_mdr_load"}, bus.mdr_load, 1'b0);
    checkd({name, "_mdr_data"}, bus.mdr_data, '0);
    check({name, "_mdr_op"}, int'(bus.mdr_op), 0);
    check1({name, "_rsp_valid"}, bus.rsp_valid, 1'b0);
    checkd({name, "_rsp_result"}, bus.rsp_result, '0);
    checkd({name, "_rsp_reminder"}, bus.rsp_reminder, '0);
    check1({name, "_rsp_error"}, bus.rsp_error, 1'b0);
    check1({name, "_rsp_timeout"}, bus.rsp_timeout, 1'b0);
    check({name, "_state"}, int'(dbg_state), int'(ST_IDLE));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [DW-1:0] gx;
    int k, s0, r0;
    logic [1:0] rop;
    logic [DW-1:0] rx, ry;

    bus.req_valid    = 1'b0;
    bus.req_op       = 2'b00;
    bus.req_x        = '0;
    bus.req_y        = '0;
    bus.mdr_load_x   = 1'b0;
    bus.mdr_load_y   = 1'b0;
    bus.mdr_ready    = 1'b0;
    bus.mdr_error    = 1'b0;
    bus.mdr_result   = '0;
    bus.mdr_reminder = '0;

    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b1;
    tick();

    run_txn("mul_300x200", 2'b00, 16'd300, 16'd200, 0, 2, 3);
    run_txn("div_1000_7", 2'b01, 16'd1000, 16'd7, 1, 0, 4);
    run_txn("sqrt_144", 2'b10, 16'd144, 16'hBEEF, 2, 0, 2);
    run_txn("div_by_zero", 2'b01, 16'd55, 16'd0, 0, 1, 2);

    // Illegal op: response one cycle after acceptance, no Start.
    s0 = n_start;
    send_req(2'b11, 16'd9, 16'd9);
    check1("illegal_rsp_valid", bus.rsp_valid, 1'b1);
    check1("illegal_rsp_error", bus.rsp_error, 1'b1);
    check1("illegal_rsp_timeout", bus.rsp_timeout, 1'b0);
    check1("illegal_no_start", bus.mdr_start, 1'b0);
    tick();
    check1("illegal_rsp_single", bus.rsp_valid, 1'b0);
    check1("illegal_ready_again", bus.req_ready, 1'b1);
    check("illegal_start_count", n_start - s0, 0);

    // Silent MDR: watchdog fires TO+1 cycles after entering WAIT_X.
    send_req(2'b00, 16'd5, 16'd6);
    tick();
    bus.mdr_result   = 16'h1234;
    bus.mdr_reminder = 16'h5678;
    k = 0;
    while (!bus.rsp_valid && k < 100) begin
      tick();
      k++;
    end
    check("timeout_latency", k, TO + 1);
    check1("timeout_flag", bus.rsp_timeout, 1'b1);
    check1("timeout_error", bus.rsp_error, 1'b1);
    checkd("timeout_result", bus.rsp_result, '0);
    checkd("timeout_reminder", bus.rsp_reminder, '0);
    tick();
    check1("timeout_ready_again", bus.req_ready, 1'b1);

    // MDR error on the very cycle the watchdog expires: the error wins.
    send_req(2'b01, 16'd77, 16'd3);
    tick();
    for (int i = 0; i < TO; i++) tick();
    check1("err_vs_to_no_early_rsp", bus.rsp_valid, 1'b0);
    bus.mdr_error    = 1'b1;
    bus.mdr_result   = 16'hA5A5;
    bus.mdr_reminder = 16'h0F0F;
    tick();
    bus.mdr_error = 1'b0;
    check1("err_vs_to_rsp_valid", bus.rsp_valid, 1'b1);
    check1("err_vs_to_error", bus.rsp_error, 1'b1);
    check1("err_vs_to_timeout", bus.rsp_timeout, 1'b0);
    checkd("err_vs_to_result", bus.rsp_result, 16'hA5A5);
    checkd("err_vs_to_reminder", bus.rsp_reminder, 16'h0F0F);
    tick();

    // Randomized transactions.
    for (int n = 0; n < 12; n++) begin
      rop = 2'($urandom_range(0, 2));
      rx  = (rop == 2'b00) ? DW'($urandom_range(0, 255)) : DW'($urandom_range(0, 65535));
      ry  = (rop == 2'b00) ? DW'($urandom_range(0, 255)) : DW'($urandom_range(1, 65535));
      run_txn("rand", rop, rx, ry, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 5)));
    end

    // Reset while waiting for Load_Y: back to idle, no response.
    send_req(2'b00, 16'd7, 16'd9);
    tick();
    serve_load(1'b0, 1, 16'd7, gx);
    check("pre_reset_in_wait_y", int'(dbg_state), int'(ST_WAIT_Y));
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    r0 = n_rsp;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("mid_reset_no_rsp", n_rsp - r0, 0);
    check1("mid_reset_rsp_low", bus.rsp_valid, 1'b0);
    run_txn("mul_3x4_after_reset", 2'b00, 16'd3, 16'd4, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
